uart_rx_fifo: RTL

Receive-side buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents on its done strobe into a circular FIFO. The bus side drains bytes with a first-word-fall-through read handshake, so the host can lag the serial line by up to DEPTH characters. Bytes arriving while the FIFO is full are dropped, and a sticky overrun flag is raised.

---
 rtl/uart_rx_fifo.sv | 74 +++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through reads,
// drops bytes when full and latches a sticky overrun flag.
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overrun_q;
    logic              wr_acc, rd_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthCnt);

    // A read in the same cycle frees the slot, so a write while full still lands.
    assign wr_acc = wr && (!full || rd);
    assign rd_acc = rd && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + ADDR_W'(1);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            // Set wins over a same-cycle clear.
            if (wr && full && !rd) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem_q[wptr_q] <= w_data;
        end
    end

    assign r_data  = empty ? '0 : mem_q[rptr_q];
    assign count   = count_q;
    assign overrun = overrun_q;

endmodule
